// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder for the sequence detectors: words arrive over valid/ready
// and leave one bit per clock on `a`, with a one-word holding register for gapless streaming.
module serial_bit_source #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic         clc,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         a,
    output logic         a_valid,
    output logic         a_last,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   sreg, sreg_n;
    logic [W-1:0]   hold, hold_n;
    logic           hold_full, hold_full_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           a_n, a_valid_n, a_last_n;
    logic           accept;
    logic           do_load;
    logic [W-1:0]   load_src;

    // Bit that leaves the word first, and the word with that bit consumed.
    function automatic logic head(input logic [W-1:0] w);
        return MSB_FIRST ? w[W-1] : w[0];
    endfunction

    function automatic logic [W-1:0] consume(input logic [W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready = !hold_full && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = a_valid || hold_full;

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        a_n         = a;
        a_valid_n   = a_valid;
        a_last_n    = a_last;
        do_load     = 1'b0;
        load_src    = in_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (!a_last) begin
                    a_n      = head(sreg);
                    sreg_n   = consume(sreg);
                    cnt_n    = cnt + CW'(1);
                    a_last_n = (cnt_n == LAST_CNT);
                    if (accept) begin
                        hold_n      = in_data;
                        hold_full_n = 1'b1;
                    end
                end else if (hold_full) begin
                    // A held word always wins over a new one; in_ready is low here anyway.
                    do_load     = 1'b1;
                    load_src    = hold;
                    hold_full_n = 1'b0;
                end else if (accept) begin
                    do_load = 1'b1;
                end else begin
                    state_n   = IDLE;
                    a_n       = IDLE_BIT;
                    a_valid_n = 1'b0;
                    a_last_n  = 1'b0;
                    cnt_n     = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_load) begin
            state_n   = SHIFT;
            a_n       = head(load_src);
            sreg_n    = consume(load_src);
            cnt_n     = '0;
            a_valid_n = 1'b1;
            a_last_n  = 1'b0;
        end
    end

    always_ff @(posedge clc) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            a         <= IDLE_BIT;
            a_valid   <= 1'b0;
            a_last    <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
            a         <= a_n;
            a_valid   <= a_valid_n;
            a_last    <= a_last_n;
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: an MSB-first instance carries most scenarios,
// a second LSB-first instance checks the reversed bit order.
module tb_serial_bit_source;

    logic       clc;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       a, a_valid, a_last, busy;
    logic       in_valid_l, in_ready_l;
    logic [7:0] in_data_l;
    logic       a_l, a_valid_l, a_last_l, busy_l;

    int errors = 0;
    int checks = 0;

    serial_bit_source #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clc(clc), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a(a), .a_valid(a_valid), .a_last(a_last), .busy(busy)
    );

    serial_bit_source #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clc(clc), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
        .a(a_l), .a_valid(a_valid_l), .a_last(a_last_l), .busy(busy_l)
    );

    initial begin
        clc = 1'b0;
        forever #5 clc = ~clc;
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        @(posedge clc);
        #1;
        rst      = r;
        in_valid = v;
        in_data  = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  word;
        logic [7:0]  word_b;
        logic [7:0]  words [3];
        logic [23:0] stream;
        int          idx;
        int          det;
        logic        exp_ready;

        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        in_valid_l = 1'b0;
        in_data_l  = 8'h00;

        $display("[TB] reset hold with valid data presented");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hFF);
            checkOutput("rst_in_ready", in_ready, 0);
            checkOutput("rst_a_valid", a_valid, 0);
            checkOutput("rst_a", a, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_lsb_ready", in_ready_l, 0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_a_valid", a_valid, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("post_rst_quiet", {a_valid, a, a_last, busy}, 4'b0000);
        end

        $display("[TB] single word 0xB3 MSB first");
        word = 8'hB3;
        applyStimulus(1'b0, 1'b1, word);
        checkOutput("b3_accept_ready", in_ready, 1);
        checkOutput("b3_accept_avalid", a_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("b3_bit%0d", i), a, word[8-i]);
            checkOutput($sformatf("b3_valid%0d", i), a_valid, 1);
            checkOutput($sformatf("b3_last%0d", i), a_last, (i == 8));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b3_after_valid", a_valid, 0);
        checkOutput("b3_after_a", a, 0);
        checkOutput("b3_after_busy", busy, 0);

        $display("[TB] streaming 0xCC 0x33 0xA5");
        words[0] = 8'hCC;
        words[1] = 8'h33;
        words[2] = 8'hA5;
        idx      = 0;
        stream   = '0;
        for (int k = 0; k <= 24; k++) begin
            if (idx < 3) applyStimulus(1'b0, 1'b1, words[idx]);
            else         applyStimulus(1'b0, 1'b0, 8'h00);
            exp_ready = (k == 0) || (k == 1) || (k == 9) || (k >= 17);
            checkOutput($sformatf("stream_ready%0d", k), in_ready, exp_ready);
            if (k >= 1) begin
                stream = {stream[22:0], a};
                checkOutput($sformatf("stream_valid%0d", k), a_valid, 1);
                checkOutput($sformatf("stream_last%0d", k), a_last, (k % 8 == 0));
                checkOutput($sformatf("stream_busy%0d", k), busy, 1);
            end
            if (idx < 3 && exp_ready) idx++;
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("stream_end_valid", a_valid, 0);
        checkOutput("stream_bits", stream, 24'hCC33A5);
        det = 0;
        for (int p = 0; p <= 18; p++) begin
            if (stream[23-p -: 6] == 6'b110011) det++;
        end
        checkOutput("stream_110011_hits", det, 2);

        $display("[TB] word presented in the previous word's last cycle");
        word   = 8'h81;
        word_b = 8'h7E;
        applyStimulus(1'b0, 1'b1, word);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("lca_a_bit%0d", i), a, word[8-i]);
        end
        applyStimulus(1'b0, 1'b1, word_b);
        checkOutput("lca_a_last", a_last, 1);
        checkOutput("lca_a_bit8", a, word[0]);
        checkOutput("lca_ready_in_last", in_ready, 1);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("lca_b_bit%0d", j), a, word_b[8-j]);
            checkOutput($sformatf("lca_b_valid%0d", j), a_valid, 1);
            checkOutput($sformatf("lca_b_last%0d", j), a_last, (j == 8));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("lca_end_valid", a_valid, 0);

        $display("[TB] reset mid-word with a held word");
        applyStimulus(1'b0, 1'b1, 8'hF0);
        checkOutput("mid_accept_ready", in_ready, 1);
        applyStimulus(1'b0, 1'b1, 8'h0F);
        checkOutput("mid_bit1", a, 1);
        checkOutput("mid_hold_ready", in_ready, 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid_bit2", a, 1);
        checkOutput("mid_full_ready", in_ready, 0);
        checkOutput("mid_full_busy", busy, 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid_bit3", a, 1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("mid_rst_ready", in_ready, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid_after_valid", a_valid, 0);
        checkOutput("mid_after_busy", busy, 0);
        checkOutput("mid_after_a", a, 0);
        checkOutput("mid_after_last", a_last, 0);
        checkOutput("mid_after_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("mid_quiet%0d", i), {a_valid, a, busy}, 3'b000);
        end

        $display("[TB] LSB-first word 0x01");
        applyStimulus(1'b0, 1'b0, 8'h00);
        in_valid_l = 1'b1;
        in_data_l  = 8'h01;
        #1;
        checkOutput("lsb_ready", in_ready_l, 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            in_valid_l = 1'b0;
            in_data_l  = 8'h00;
            checkOutput($sformatf("lsb_bit%0d", i), a_l, (i == 1));
            checkOutput($sformatf("lsb_valid%0d", i), a_valid_l, 1);
            checkOutput($sformatf("lsb_last%0d", i), a_last_l, (i == 8));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("lsb_end_valid", a_valid_l, 0);
        checkOutput("lsb_end_busy", busy_l, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
